// File: rtl/npu_cmd_if.sv
// EX-stage NPU command bundle: pipeline side drives the request, responder
// returns stall/valid/result.
interface npu_cmd_if #(
    parameter int XLEN = 32
);
    logic            en_npu;
    logic [3:0]      npu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            hold;
    logic            npu_stall;
    logic            npu_valid;
    logic [XLEN-1:0] npu_result;
    logic            npu_illegal;
    logic [XLEN-1:0] acc_out;

    modport master (
        output en_npu, npu_op, op_a, op_b, flush, hold,
        input  npu_stall, npu_valid, npu_result, npu_illegal, acc_out
    );

    modport slave (
        input  en_npu, npu_op, op_a, op_b, flush, hold,
        output npu_stall, npu_valid, npu_result, npu_illegal, acc_out
    );
endinterface

// File: rtl/npu_cmd_responder.sv
// NPU responder beside the ALU: signed int8 dot-product-accumulate over
// LANES cycles, or single-cycle accumulator ops, with pipeline stall.
module npu_cmd_responder #(
    parameter int         XLEN     = 32,
    parameter int         LANES    = 4,
    parameter int         LANE_W   = 8,
    parameter logic [3:0] OP_DOT4  = 4'b1000,
    parameter logic [3:0] OP_CLR   = 4'b1001,
    parameter logic [3:0] OP_RDACC = 4'b1010,
    parameter logic [3:0] OP_RELU  = 4'b1011
) (
    input  logic      clk,
    input  logic      rst,
    npu_cmd_if.slave  cmd
);
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW  = 2 * LANE_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] acc, result, a_q, b_q, psum;
    logic [LCW-1:0]  lane_cnt;
    logic            ill_q;

    logic [LANE_W-1:0] a_lane, b_lane;
    logic [PW-1:0]     a_ext, b_ext, prod;
    logic [XLEN-1:0]   prod_ext, dot_acc, relu_acc;
    logic              last_lane, accept;

    // Both factors sign-extended to the product width, so the truncated
    // product is the correct two's complement result.
    assign a_lane    = a_q[int'(lane_cnt)*LANE_W +: LANE_W];
    assign b_lane    = b_q[int'(lane_cnt)*LANE_W +: LANE_W];
    assign a_ext     = {{LANE_W{a_lane[LANE_W-1]}}, a_lane};
    assign b_ext     = {{LANE_W{b_lane[LANE_W-1]}}, b_lane};
    assign prod      = a_ext * b_ext;
    assign prod_ext  = {{(XLEN-PW){prod[PW-1]}}, prod};
    assign dot_acc   = acc + psum + prod_ext;
    assign relu_acc  = acc[XLEN-1] ? '0 : acc;
    assign last_lane = (lane_cnt == LCW'(LANES-1));
    assign accept    = cmd.en_npu && !cmd.flush;

    always_comb begin
        state_nxt       = state;
        cmd.npu_stall   = 1'b0;
        cmd.npu_valid   = 1'b0;
        cmd.npu_illegal = 1'b0;
        case (state)
            IDLE: if (accept) begin
                cmd.npu_stall = 1'b1;
                state_nxt     = (cmd.npu_op == OP_DOT4) ? BUSY : DONE;
            end
            BUSY: begin
                cmd.npu_stall = 1'b1;
                if (cmd.flush)     state_nxt = IDLE;
                else if (last_lane) state_nxt = DONE;
            end
            DONE: begin
                cmd.npu_valid   = 1'b1;
                cmd.npu_illegal = ill_q;
                // en_npu here belongs to the completing instruction; ignore it
                if (cmd.flush || !cmd.hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            result   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            psum     <= '0;
            lane_cnt <= '0;
            ill_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_q      <= cmd.op_a;
                    b_q      <= cmd.op_b;
                    lane_cnt <= '0;
                    psum     <= '0;
                    ill_q    <= 1'b0;
                    case (cmd.npu_op)
                        OP_DOT4:  ;
                        OP_CLR: begin
                            acc    <= '0;
                            result <= '0;
                        end
                        OP_RDACC: result <= acc;
                        OP_RELU: begin
                            acc    <= relu_acc;
                            result <= relu_acc;
                        end
                        default: begin
                            result <= '0;
                            ill_q  <= 1'b1;
                        end
                    endcase
                end
                BUSY: if (!cmd.flush) begin
                    if (last_lane) begin
                        acc    <= dot_acc;
                        result <= dot_acc;
                    end else begin
                        psum     <= psum + prod_ext;
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd.npu_result = result;
    assign cmd.acc_out    = acc;
endmodule

// File: tb/tb_npu_cmd_responder.sv
// Directed bench for npu_cmd_responder: vector table plus hand-written
// flush / hold / back-to-back / reset sequences.
module tb_npu_cmd_responder;
    localparam logic [3:0] DOT4 = 4'b1000, CLR = 4'b1001, RDACC = 4'b1010, RELU = 4'b1011;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res, acc;
        logic        ill;
        int          stalls;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0, tot_cnt = 0;
    vec_t tbl[10];

    npu_cmd_if #(.XLEN(32)) cmd ();
    npu_cmd_responder dut (.clk(clk), .rst(rst), .cmd(cmd));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic run_cmd(input vec_t v, input string nm);
        int st;
        bit seen;
        @(posedge clk); #1;
        cmd.en_npu = 1'b1; cmd.npu_op = v.op; cmd.op_a = v.a; cmd.op_b = v.b;
        st = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cmd.npu_valid) seen = 1'b1;
            else if (cmd.npu_stall) st++;
        end
        chk({nm, "_valid"},   32'(seen), 32'd1);
        chk({nm, "_stalls"},  32'(st), 32'(v.stalls));
        chk({nm, "_result"},  cmd.npu_result, v.res);
        chk({nm, "_acc"},     cmd.acc_out, v.acc);
        chk({nm, "_illegal"}, 32'(cmd.npu_illegal), 32'(v.ill));
        chk({nm, "_nostall"}, 32'(cmd.npu_stall), 32'd0);
        @(posedge clk); #1;
        cmd.en_npu = 1'b0;
    endtask

    initial begin
        int p, i1, i2;
        logic [31:0] r1, r2;
        bit bad;

        tbl[0] = '{DOT4,  32'h01020304, 32'h05060708, 32'h00000046, 32'h00000046, 1'b0, 5};
        tbl[1] = '{DOT4,  32'hFFFFFFFF, 32'h02020202, 32'h0000003E, 32'h0000003E, 1'b0, 5};
        tbl[2] = '{RDACC, 32'h0,        32'h0,        32'h0000003E, 32'h0000003E, 1'b0, 1};
        tbl[3] = '{CLR,   32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b0, 1};
        tbl[4] = '{DOT4,  32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200, 32'hFFFF0200, 1'b0, 5};
        tbl[5] = '{RELU,  32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b0, 1};
        tbl[6] = '{DOT4,  32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0000FC04, 32'h0000FC04, 1'b0, 5};
        tbl[7] = '{4'b0011, 32'h1234,   32'h5678,     32'h00000000, 32'h0000FC04, 1'b1, 1};
        tbl[8] = '{RELU,  32'h0,        32'h0,        32'h0000FC04, 32'h0000FC04, 1'b0, 1};
        tbl[9] = '{DOT4,  32'h01010101, 32'hFFFFFFFF, 32'h0000FC00, 32'h0000FC00, 1'b0, 5};

        rst = 1'b1;
        cmd.en_npu = 1'b0; cmd.npu_op = '0; cmd.op_a = '0; cmd.op_b = '0;
        cmd.flush = 1'b0; cmd.hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall",   32'(cmd.npu_stall), 32'd0);
        chk("rst_valid",   32'(cmd.npu_valid), 32'd0);
        chk("rst_illegal", 32'(cmd.npu_illegal), 32'd0);
        chk("rst_result",  cmd.npu_result, 32'd0);
        chk("rst_acc",     cmd.acc_out, 32'd0);

        for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // flush in IDLE ignores the request; flush in BUSY lane 2 aborts
        @(posedge clk); #1;
        cmd.en_npu = 1'b1; cmd.npu_op = DOT4; cmd.op_a = 32'h01010101; cmd.op_b = 32'h01010101;
        cmd.flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", 32'(cmd.npu_stall), 32'd0);
        @(posedge clk); #1 cmd.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 cmd.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", 32'(cmd.npu_stall), 32'd1);
        @(posedge clk); #1;
        cmd.flush = 1'b0; cmd.en_npu = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cmd.npu_stall || cmd.npu_valid) bad = 1'b1;
        end
        chk("flush_no_stall_valid", 32'(bad), 32'd0);
        chk("flush_acc", cmd.acc_out, 32'h0000FC00);

        // hold keeps DONE alive for 3 extra cycles
        @(posedge clk); #1;
        cmd.hold = 1'b1; cmd.en_npu = 1'b1; cmd.npu_op = RDACC;
        @(posedge clk); #1 cmd.en_npu = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold_valid%0d", k), 32'(cmd.npu_valid), 32'd1);
            chk($sformatf("hold_result%0d", k), cmd.npu_result, 32'h0000FC00);
        end
        cmd.hold = 1'b0;
        @(negedge clk);
        chk("hold_release", 32'(cmd.npu_valid), 32'd0);

        // back-to-back: en_npu stays high from DOT4 straight into RDACC
        @(posedge clk); #1;
        cmd.en_npu = 1'b1; cmd.npu_op = DOT4; cmd.op_a = 32'h02020202; cmd.op_b = 32'h03030303;
        p = 0; i1 = 0; i2 = 0; r1 = '0; r2 = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cmd.npu_valid) begin
                p++;
                if (p == 1) begin i1 = c; r1 = cmd.npu_result; cmd.npu_op = RDACC; end
                else if (p == 2) begin i2 = c; r2 = cmd.npu_result; cmd.en_npu = 1'b0; end
            end
        end
        chk("b2b_pulses", 32'(p), 32'd2);
        chk("b2b_gap",    32'(i2 - i1), 32'd2);
        chk("b2b_dot",    r1, 32'h0000FC18);
        chk("b2b_rdacc",  r2, 32'h0000FC18);

        // reset in the middle of BUSY
        @(posedge clk); #1;
        cmd.en_npu = 1'b1; cmd.npu_op = DOT4; cmd.op_a = 32'h01010101; cmd.op_b = 32'h01010101;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cmd.en_npu = 1'b0;
        @(negedge clk);
        chk("mrst_stall",   32'(cmd.npu_stall), 32'd0);
        chk("mrst_valid",   32'(cmd.npu_valid), 32'd0);
        chk("mrst_illegal", 32'(cmd.npu_illegal), 32'd0);
        chk("mrst_result",  cmd.npu_result, 32'd0);
        chk("mrst_acc",     cmd.acc_out, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
